// File: rtl/pipe_ctrl.sv
// Hazard, flush and memory-wait controller for a five-stage in-order pipeline.
// Tracks EX/MEM writebacks for RAW stalls and freezes the back end on slow memory.
module pipe_ctrl #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       id_valid,
   input  logic [3:0] id_src1,
   input  logic [3:0] id_src2,
   input  logic       id_two_src,
   input  logic       id_wb_en,
   input  logic [3:0] id_dest,
   input  logic       id_mem_read,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       stall_if,
   output logic       stall_id,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       freeze,
   output logic       hazard,
   output logic       mem_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ERR  = 2'd2
   } mem_state_e;

   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   mem_state_e state_q;
   logic [7:0] cnt_q;
   logic       mem_err_q;
   logic       br_pend_q;

   logic       ex_v_q, ex_wb_q, ex_mrd_q;
   logic [3:0] ex_dest_q;
   logic       mem_v_q, mem_wb_q, mem_mrd_q;
   logic [3:0] mem_dest_q;

   logic freeze_d;
   logic hazard_d;
   logic flush_d;
   logic stall_d;
   logic ex_hit, mem_hit;
   logic src1_hit, src2_hit;

   // The load flag travels with the slot for downstream use but gates nothing here.
   logic unused_mrd;
   assign unused_mrd = ex_mrd_q ^ mem_mrd_q;

   always_comb begin
      freeze_d = 1'b0;
      unique case (state_q)
         IDLE:    freeze_d = mem_req & ~mem_ready;
         WAIT:    freeze_d = ~mem_ready;
         default: freeze_d = 1'b1;
      endcase
   end

   assign ex_hit   = ex_v_q & ex_wb_q;
   assign mem_hit  = mem_v_q & mem_wb_q;
   assign src1_hit = (ex_hit & (ex_dest_q == id_src1)) | (mem_hit & (mem_dest_q == id_src1));
   assign src2_hit = (ex_hit & (ex_dest_q == id_src2)) | (mem_hit & (mem_dest_q == id_src2));
   assign hazard_d = id_valid & (src1_hit | (id_two_src & src2_hit));

   // A branch seen while frozen is remembered so it still flushes once the freeze lifts.
   assign flush_d  = (ex_branch_taken | br_pend_q) & ~freeze_d;
   assign stall_d  = (hazard_d & ~flush_d) | freeze_d;

   assign hazard      = hazard_d;
   assign freeze      = freeze_d;
   assign stall_if    = stall_d;
   assign stall_id    = stall_d;
   assign flush_if_id = flush_d;
   assign flush_id_ex = flush_d;
   assign mem_err     = mem_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (mem_req && !mem_ready) begin
                  state_q <= WAIT;
                  cnt_q   <= 8'd0;
               end
            end
            WAIT: begin
               if (mem_ready) begin
                  state_q <= IDLE;
               end else if (cnt_q == LAST_CNT) begin
                  state_q   <= ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ERR: begin
               mem_err_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_pend_q <= 1'b0;
      end else if (freeze_d) begin
         br_pend_q <= br_pend_q | ex_branch_taken;
      end else begin
         br_pend_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_v_q     <= 1'b0;
         ex_wb_q    <= 1'b0;
         ex_dest_q  <= 4'd0;
         ex_mrd_q   <= 1'b0;
         mem_v_q    <= 1'b0;
         mem_wb_q   <= 1'b0;
         mem_dest_q <= 4'd0;
         mem_mrd_q  <= 1'b0;
      end else if (!freeze_d) begin
         mem_v_q    <= ex_v_q;
         mem_wb_q   <= ex_wb_q;
         mem_dest_q <= ex_dest_q;
         mem_mrd_q  <= ex_mrd_q;
         if (stall_d || flush_d) begin
            ex_v_q    <= 1'b0;
            ex_wb_q   <= 1'b0;
            ex_dest_q <= 4'd0;
            ex_mrd_q  <= 1'b0;
         end else begin
            ex_v_q    <= id_valid;
            ex_wb_q   <= id_wb_en;
            ex_dest_q <= id_dest;
            ex_mrd_q  <= id_mem_read;
         end
      end
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum number of consecutive WAIT cycles before a memory timeout is declared (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 SHALL have port rst, input, 1, meaning the asynchronous active-high reset.
REQ-004 SHALL have port id_valid, input, 1, meaning the ID stage holds a real instruction.
REQ-005 SHALL have ports id_src1 and id_src2, input, 4 each, meaning the ID-stage source register numbers.
REQ-006 SHALL have port id_two_src, input, 1, meaning id_src2 is actually read by the ID-stage instruction.
REQ-007 SHALL have ports id_wb_en (1), id_dest (4) and id_mem_read (1), input, meaning the ID-stage writeback enable, destination and load flag.
REQ-008 SHALL have port ex_branch_taken, input, 1, meaning the EX stage resolves a taken branch this cycle.
REQ-009 SHALL have ports mem_req and mem_ready, input, 1 each, meaning the MEM-stage access request and the memory completion strobe.
REQ-010 SHALL have ports stall_if and stall_id, output, 1 each, meaning hold PC and hold the IF/ID register.
REQ-011 SHALL have ports flush_if_id and flush_id_ex, output, 1 each, meaning load a bubble into IF/ID and into ID/EX respectively.
REQ-012 SHALL have port freeze, output, 1, meaning hold ID/EX, EX/MEM and MEM/WB.
REQ-013 SHALL have ports hazard (1) and mem_err (1, sticky), output, meaning a RAW hazard is detected and a memory timeout has occurred.

Function
REQ-014 SHALL keep scoreboard slots ex_slot and mem_slot, each holding {v, wb, dest[3:0], mrd}.
REQ-015 SHALL, at each edge with freeze=0, load mem_slot from ex_slot.
REQ-016 SHALL, at each edge with freeze=0, load ex_slot from the ID inputs, or with v=0 when stall_id=1 or flush_id_ex=1.
REQ-017 SHALL hold both scoreboard slots unchanged while freeze=1.
REQ-018 SHALL compute hazard combinationally as id_valid AND (src1 matches OR (id_two_src AND src2 matches)), where a match means equal to the dest of a slot with v=1 and wb=1, checked against both slots.
REQ-019 SHALL drive stall_if = stall_id = (hazard AND NOT flush) OR freeze.
REQ-020 SHALL drive flush_if_id = flush_id_ex = ex_branch_taken AND NOT freeze; flush has priority over hazard.
REQ-021 SHALL defer a branch arriving while freeze=1, because the branch stays held in EX, and SHALL flush on the first unfrozen cycle.
REQ-022 SHALL implement memory FSM states IDLE, WAIT and ERR.
REQ-023 SHALL, in IDLE: if mem_req=1 and mem_ready=0, set freeze=1, go to WAIT and clear cnt to 0; otherwise freeze=0.
REQ-024 SHALL, in WAIT: set freeze = NOT mem_ready; mem_ready=1 returns to IDLE with no freeze that cycle; otherwise cnt increments.
REQ-025 SHALL, in WAIT with cnt = MAX_WAIT-1 and mem_ready=0, enter ERR.
REQ-026 SHALL, in ERR, hold freeze=1 and mem_err=1 until reset; mem_ready is ignored.
REQ-027 SHALL size cnt at 8 bits and SHALL never let it wrap.
REQ-028 SHALL complete a zero-wait access (mem_req and mem_ready together in IDLE) with no freeze.

Reset
REQ-029 SHALL, while rst=1, asynchronously clear both slot v bits, set FSM to IDLE, clear cnt to 0 and clear mem_err to 0.
REQ-030 SHALL, after reset, hold all outputs at 0 until inputs request otherwise.
REQ-031 SHALL honour a reset asserted mid-WAIT or in ERR immediately, without waiting for a clock edge.

Verification
REQ-032 SHALL cover: ID writes r3 (wb=1) at cycle 0, then the next ID reads src1=3 -> hazard=1 and stall_id=1 for exactly 2 cycles, then the instruction proceeds.
REQ-033 SHALL cover: a hazard on src2=5 with id_two_src=0 -> hazard=0.
REQ-034 SHALL cover: ex_branch_taken=1 together with a hazard -> flush_if_id=1, flush_id_ex=1, stall_id=0, and ex_slot.v=0 next cycle.
REQ-035 SHALL cover: mem_req=1 with mem_ready arriving 3 cycles later -> freeze=1 for exactly 3 cycles, FSM back in IDLE, scoreboard unchanged throughout.
REQ-036 SHALL cover: MAX_WAIT=4 with mem_ready never asserted -> ERR after 5 frozen cycles, mem_err=1 and sticky; rst pulse -> mem_err=0 and freeze=0 at once.
REQ-037 SHALL cover: ex_branch_taken=1 during freeze -> no flush until the cycle freeze drops, then one flush cycle.
